// File: rtl/alu_pkg.sv
// ALU encodings shared by the issue stage and the ALU.
package alu_pkg;

    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [CTRL_W-1:0] ALU_AND     = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR      = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD     = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB     = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [ALUOP_W-1:0] ALUOP_MEM   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR    = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_ARITH = 2'b10;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU-op / funct decode into the 4-bit ALU control word.
module alu_control
    import alu_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               is_imm,
    output logic [CTRL_W-1:0]  alu_control_c,
    output logic               illegal_c
);

    // Decode; anything not recognised falls through as illegal.
    always_comb begin
        alu_control_c = ALU_ILLEGAL;
        illegal_c     = 1'b1;
        case (alu_op)
            ALUOP_MEM: begin
                alu_control_c = ALU_ADD;
                illegal_c     = 1'b0;
            end
            ALUOP_BR: begin
                alu_control_c = ALU_SUB;
                illegal_c     = 1'b0;
            end
            ALUOP_ARITH: begin
                case (funct3)
                    3'b000: begin
                        // Immediate forms never subtract, even with bit 30 set.
                        alu_control_c = (funct7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
                        illegal_c     = 1'b0;
                    end
                    3'b111: begin
                        alu_control_c = ALU_AND;
                        illegal_c     = 1'b0;
                    end
                    3'b110: begin
                        alu_control_c = ALU_OR;
                        illegal_c     = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage ahead of the ALU: operand select, decode, 2-entry skid buffer.
// Optional operand forwarding from EX/WB when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [ALUOP_W-1:0]    inAluOp,
    input  logic [2:0]            inFunct3,
    input  logic                  inFunct7b5,
    input  logic                  inIsImm,
    input  logic [REG_ADDR_W-1:0] inRs1Addr,
    input  logic [REG_ADDR_W-1:0] inRs2Addr,
    input  logic [XLEN-1:0]       inRs1Data,
    input  logic [XLEN-1:0]       inRs2Data,
    input  logic [XLEN-1:0]       inImm,
    input  logic [REG_ADDR_W-1:0] inRd,
`ifdef ALU_ISSUE_FWD_EN
    input  logic                  exFwdValid,
    input  logic [REG_ADDR_W-1:0] exFwdRd,
    input  logic [XLEN-1:0]       exFwdData,
    input  logic                  wbFwdValid,
    input  logic [REG_ADDR_W-1:0] wbFwdRd,
    input  logic [XLEN-1:0]       wbFwdData,
`endif
    output logic                  outValid,
    input  logic                  outReady,
    output logic [XLEN-1:0]       x,
    output logic [XLEN-1:0]       y,
    output logic [CTRL_W-1:0]     aluControl,
    output logic [REG_ADDR_W-1:0] outRd,
    output logic                  outIllegal
);

    logic [XLEN-1:0]       rs1_value, rs2_value, new_y;
    logic [CTRL_W-1:0]     new_ctrl;
    logic                  new_ill;
    logic                  accept;

    logic                  skid_valid;
    logic [XLEN-1:0]       skid_x, skid_y;
    logic [CTRL_W-1:0]     skid_ctrl;
    logic [REG_ADDR_W-1:0] skid_rd;
    logic                  skid_ill;

    logic                  n_main_valid, n_skid_valid, n_in_ready;
    logic [XLEN-1:0]       n_x, n_y, n_skid_x, n_skid_y;
    logic [CTRL_W-1:0]     n_ctrl, n_skid_ctrl;
    logic [REG_ADDR_W-1:0] n_rd, n_skid_rd;
    logic                  n_ill, n_skid_ill;

    alu_control u_alu_control (
        .alu_op        (inAluOp),
        .funct3        (inFunct3),
        .funct7b5      (inFunct7b5),
        .is_imm        (inIsImm),
        .alu_control_c (new_ctrl),
        .illegal_c     (new_ill)
    );

    // Source operand values, with EX taking priority over WB; index 0 never forwards.
    always_comb begin
        rs1_value = inRs1Data;
        rs2_value = inRs2Data;
`ifdef ALU_ISSUE_FWD_EN
        if (inRs1Addr != '0) begin
            if (exFwdValid && exFwdRd == inRs1Addr)      rs1_value = exFwdData;
            else if (wbFwdValid && wbFwdRd == inRs1Addr) rs1_value = wbFwdData;
        end
        if (inRs2Addr != '0) begin
            if (exFwdValid && exFwdRd == inRs2Addr)      rs2_value = exFwdData;
            else if (wbFwdValid && wbFwdRd == inRs2Addr) rs2_value = wbFwdData;
        end
`else
        if (inRs1Addr == inRs2Addr) begin
            rs1_value = inRs1Data;
        end
`endif
    end

    assign new_y  = inIsImm ? inImm : rs2_value;
    assign accept = inValid && inReady && !flush;

    // Next state for main/skid entries; skid refills main as soon as main drains.
    always_comb begin
        n_main_valid = outValid;
        n_x          = x;
        n_y          = y;
        n_ctrl       = aluControl;
        n_rd         = outRd;
        n_ill        = outIllegal;
        n_skid_valid = skid_valid;
        n_skid_x     = skid_x;
        n_skid_y     = skid_y;
        n_skid_ctrl  = skid_ctrl;
        n_skid_rd    = skid_rd;
        n_skid_ill   = skid_ill;
        if (flush) begin
            n_main_valid = 1'b0;
            n_skid_valid = 1'b0;
        end else if (!outValid || outReady) begin
            if (skid_valid) begin
                // inReady is low while skid is full, so nothing is accepted here.
                n_main_valid = 1'b1;
                n_x          = skid_x;
                n_y          = skid_y;
                n_ctrl       = skid_ctrl;
                n_rd         = skid_rd;
                n_ill        = skid_ill;
                n_skid_valid = 1'b0;
            end else begin
                n_main_valid = accept;
                if (accept) begin
                    n_x    = rs1_value;
                    n_y    = new_y;
                    n_ctrl = new_ctrl;
                    n_rd   = inRd;
                    n_ill  = new_ill;
                end
            end
        end else if (accept) begin
            n_skid_valid = 1'b1;
            n_skid_x     = rs1_value;
            n_skid_y     = new_y;
            n_skid_ctrl  = new_ctrl;
            n_skid_rd    = inRd;
            n_skid_ill   = new_ill;
        end
        n_in_ready = !n_skid_valid;
    end

    // State registers; main entry drives the outputs directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            inReady    <= 1'b0;
            outValid   <= 1'b0;
            x          <= '0;
            y          <= '0;
            aluControl <= ALU_AND;
            outRd      <= '0;
            outIllegal <= 1'b0;
            skid_valid <= 1'b0;
            skid_x     <= '0;
            skid_y     <= '0;
            skid_ctrl  <= ALU_AND;
            skid_rd    <= '0;
            skid_ill   <= 1'b0;
        end else begin
            inReady    <= n_in_ready;
            outValid   <= n_main_valid;
            x          <= n_x;
            y          <= n_y;
            aluControl <= n_ctrl;
            outRd      <= n_rd;
            outIllegal <= n_ill;
            skid_valid <= n_skid_valid;
            skid_x     <= n_skid_x;
            skid_y     <= n_skid_y;
            skid_ctrl  <= n_skid_ctrl;
            skid_rd    <= n_skid_rd;
            skid_ill   <= n_skid_ill;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (forwarding test under ALU_ISSUE_FWD_EN).
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, flush, inValid, inReady;
    logic [1:0]  inAluOp;
    logic [2:0]  inFunct3;
    logic        inFunct7b5, inIsImm;
    logic [4:0]  inRs1Addr, inRs2Addr, inRd, outRd;
    logic [63:0] inRs1Data, inRs2Data, inImm, x, y;
    logic        outValid, outReady, outIllegal;
    logic [3:0]  aluControl;
`ifdef ALU_ISSUE_FWD_EN
    logic        exFwdValid, wbFwdValid;
    logic [4:0]  exFwdRd, wbFwdRd;
    logic [63:0] exFwdData, wbFwdData;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .inAluOp    (inAluOp),
        .inFunct3   (inFunct3),
        .inFunct7b5 (inFunct7b5),
        .inIsImm    (inIsImm),
        .inRs1Addr  (inRs1Addr),
        .inRs2Addr  (inRs2Addr),
        .inRs1Data  (inRs1Data),
        .inRs2Data  (inRs2Data),
        .inImm      (inImm),
        .inRd       (inRd),
`ifdef ALU_ISSUE_FWD_EN
        .exFwdValid (exFwdValid),
        .exFwdRd    (exFwdRd),
        .exFwdData  (exFwdData),
        .wbFwdValid (wbFwdValid),
        .wbFwdRd    (wbFwdRd),
        .wbFwdData  (wbFwdData),
`endif
        .outValid   (outValid),
        .outReady   (outReady),
        .x          (x),
        .y          (y),
        .aluControl (aluControl),
        .outRd      (outRd),
        .outIllegal (outIllegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic imm_sel, input logic [63:0] r1, input logic [63:0] r2,
                          input logic [63:0] imm, input logic [4:0] rd);
        inAluOp    = op;
        inFunct3   = f3;
        inFunct7b5 = f7;
        inIsImm    = imm_sel;
        inRs1Data  = r1;
        inRs2Data  = r2;
        inImm      = imm;
        inRd       = rd;
    endtask

    // Single pass-through with outReady high; checks the decoded control word.
    task automatic one_shot(input string tag, input logic [1:0] op, input logic [2:0] f3,
                            input logic f7, input logic imm_sel,
                            input logic [3:0] exp_ctrl, input logic exp_ill);
        set_op(op, f3, f7, imm_sel, 64'h10, 64'h20, 64'h30, 5'd9);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        chk({tag, "_valid"}, 64'(outValid), 64'd1);
        chk({tag, "_ctrl"}, 64'(aluControl), 64'(exp_ctrl));
        chk({tag, "_ill"}, 64'(outIllegal), 64'(exp_ill));
        chk({tag, "_y"}, y, imm_sel ? 64'h30 : 64'h20);
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inRs1Addr = 5'd1; inRs2Addr = 5'd2;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd0);
`ifdef ALU_ISSUE_FWD_EN
        exFwdValid = 1'b0; exFwdRd = 5'd0; exFwdData = 64'h0;
        wbFwdValid = 1'b0; wbFwdRd = 5'd0; wbFwdData = 64'h0;
`endif

        // 1. reset
        step();
        step();
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_ctrl", 64'(aluControl), 64'd0);
        chk("rst_inReady", 64'(inReady), 64'd0);
        chk("rst_x", x, 64'd0);
        chk("rst_rd", 64'(outRd), 64'd0);
        reset = 1'b0;
        step();
        chk("post_rst_inReady", 64'(inReady), 64'd1);
        chk("post_rst_outValid", 64'(outValid), 64'd0);

        // 2. SUB register form, 1-cycle latency
        outReady = 1'b1;
        set_op(2'b10, 3'b000, 1'b1, 1'b0, 64'h5, 64'h3, 64'h77, 5'd4);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        chk("sub_valid", 64'(outValid), 64'd1);
        chk("sub_x", x, 64'h5);
        chk("sub_y", y, 64'h3);
        chk("sub_ctrl", 64'(aluControl), 64'h6);
        chk("sub_rd", 64'(outRd), 64'd4);
        chk("sub_ill", 64'(outIllegal), 64'd0);
        step();
        chk("sub_drained", 64'(outValid), 64'd0);

        // 3. backpressure: two accepted, third refused, FIFO drain
        outReady = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'h11, 64'h0, 64'h0, 5'd11);
        inValid = 1'b1;
        step();
        chk("bp_a_x", x, 64'h11);
        chk("bp_ready_after_a", 64'(inReady), 64'd1);
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'h22, 64'h0, 64'h0, 5'd12);
        step();
        chk("bp_ready_full", 64'(inReady), 64'd0);
        chk("bp_hold_x", x, 64'h11);
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'h33, 64'h0, 64'h0, 5'd13);
        step();
        chk("bp_c_refused_x", x, 64'h11);
        chk("bp_c_refused_rd", 64'(outRd), 64'd11);
        chk("bp_ready_still0", 64'(inReady), 64'd0);
        inValid = 1'b0;
        outReady = 1'b1;
        step();
        chk("bp_b_x", x, 64'h22);
        chk("bp_b_rd", 64'(outRd), 64'd12);
        chk("bp_b_valid", 64'(outValid), 64'd1);
        chk("bp_ready_back", 64'(inReady), 64'd1);
        step();
        chk("bp_empty", 64'(outValid), 64'd0);

        // 4. decode table
        one_shot("illegal_f3", 2'b10, 3'b001, 1'b0, 1'b0, 4'hF, 1'b1);
        one_shot("and", 2'b10, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0);
        one_shot("or", 2'b10, 3'b110, 1'b0, 1'b0, 4'h1, 1'b0);
        one_shot("addi_f7", 2'b10, 3'b000, 1'b1, 1'b1, 4'h2, 1'b0);
        one_shot("add_reg", 2'b10, 3'b000, 1'b0, 1'b0, 4'h2, 1'b0);
        one_shot("branch", 2'b01, 3'b000, 1'b0, 1'b0, 4'h6, 1'b0);
        one_shot("aluop11", 2'b11, 3'b000, 1'b0, 1'b0, 4'hF, 1'b1);
        set_op(2'b00, 3'b000, 1'b0, 1'b1, 64'h100, 64'h7, 64'hFFFF_FFFF_FFFF_FFF8, 5'd3);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        chk("mem_y", y, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("mem_x", x, 64'h100);
        chk("mem_ctrl", 64'(aluControl), 64'h2);
        step();

        // 5. flush with both entries full plus an incoming entry
        outReady = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'hD, 64'h0, 64'h0, 5'd21);
        inValid = 1'b1;
        step();
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'hE, 64'h0, 64'h0, 5'd22);
        step();
        chk("fl_full", 64'(inReady), 64'd0);
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'hF, 64'h0, 64'h0, 5'd23);
        flush = 1'b1;
        step();
        flush = 1'b0;
        inValid = 1'b0;
        chk("fl_outValid", 64'(outValid), 64'd0);
        chk("fl_inReady", 64'(inReady), 64'd1);
        outReady = 1'b1;
        step();
        chk("fl_no_ghost1", 64'(outValid), 64'd0);
        step();
        chk("fl_no_ghost2", 64'(outValid), 64'd0);

`ifdef ALU_ISSUE_FWD_EN
        // 6. forwarding priority and index-0 exclusion
        inRs1Addr = 5'd7;
        exFwdValid = 1'b1; exFwdRd = 5'd7; exFwdData = 64'hAA;
        wbFwdValid = 1'b1; wbFwdRd = 5'd7; wbFwdData = 64'hBB;
        set_op(2'b00, 3'b000, 1'b0, 1'b1, 64'h99, 64'h0, 64'h1, 5'd1);
        inValid = 1'b1;
        step();
        chk("fwd_ex_x", x, 64'hAA);
        exFwdValid = 1'b0;
        step();
        chk("fwd_wb_x", x, 64'hBB);
        inRs1Addr = 5'd0;
        exFwdValid = 1'b1; exFwdRd = 5'd0;
        wbFwdRd = 5'd0;
        step();
        inValid = 1'b0;
        chk("fwd_r0_x", x, 64'h99);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
